// File: rtl/sparse_vector_compressor_pkg.sv
// rtl/sparse_vector_compressor_pkg.sv - shared sizes and state encoding for the sparse vector compressor
package sparse_vector_compressor_pkg;
    localparam int LANES      = 16;
    localparam int BYTE_W     = 8;
    localparam int LANE_IDX_W = $clog2(LANES);
    localparam int BCNT_W     = $clog2(LANES) + 1;
    localparam int VEC_W      = LANES * BYTE_W;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;
endpackage

// File: rtl/sparse_vector_compressor_if.sv
// rtl/sparse_vector_compressor_if.sv - vector input, mask output and packed beat output handshakes
interface sparse_vector_compressor_if;
    import sparse_vector_compressor_pkg::*;

    logic [VEC_W-1:0]  vec_in;
    logic              vec_in_vld;
    logic              vec_in_last;
    logic              vec_in_rdy;
    logic [LANES-1:0]  mask_out;
    logic              mask_vld;
    logic              mask_rdy;
    logic [VEC_W-1:0]  data_out;
    logic [BCNT_W-1:0] data_bytes;
    logic              data_last;
    logic              data_vld;
    logic              data_rdy;

    modport slave (
        input  vec_in, vec_in_vld, vec_in_last, mask_rdy, data_rdy,
        output vec_in_rdy, mask_out, mask_vld, data_out, data_bytes, data_last, data_vld
    );

    modport master (
        output vec_in, vec_in_vld, vec_in_last, mask_rdy, data_rdy,
        input  vec_in_rdy, mask_out, mask_vld, data_out, data_bytes, data_last, data_vld
    );
endinterface

// File: rtl/sparse_vector_compressor_lane_compact.sv
// rtl/sparse_vector_compressor_lane_compact.sv - nonzero detect, popcount and ascending-lane compaction of one vector
module sparse_lane_compact
    import sparse_vector_compressor_pkg::*;
(
    input  logic [VEC_W-1:0]  vec,
    input  logic              double_byte_mode,
    output logic [LANES-1:0]  nz,
    output logic [BCNT_W-1:0] pop,
    output logic [VEC_W-1:0]  compact
);
    logic [LANES-1:0][BYTE_W-1:0] lanes;
    logic [LANES-1:0][BYTE_W-1:0] compact_arr;
    logic [BCNT_W-1:0]            pos;

    assign lanes   = vec;
    assign compact = compact_arr;
    assign pop     = pos;

    always_comb begin
        nz          = '0;
        compact_arr = '0;
        pos         = '0;
        for (int k = 0; k < LANES / 2; k++) begin
            if (double_byte_mode) begin
                nz[2*k]   = |{lanes[2*k+1], lanes[2*k]};
                nz[2*k+1] = |{lanes[2*k+1], lanes[2*k]};
            end else begin
                nz[2*k]   = |lanes[2*k];
                nz[2*k+1] = |lanes[2*k+1];
            end
        end
        // pos never exceeds LANES-1 before an increment, so the narrow index is safe
        for (int i = 0; i < LANES; i++) begin
            if (nz[i]) begin
                compact_arr[pos[LANE_IDX_W-1:0]] = lanes[i];
                pos = pos + 1'b1;
            end
        end
    end
endmodule

// File: rtl/sparse_vector_compressor.sv
// rtl/sparse_vector_compressor.sv - dense weight vectors to sparse bitmask plus packed nonzero-byte beats
module sparse_vector_compressor
    import sparse_vector_compressor_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       double_byte_mode,
    sparse_vector_compressor_if.slave  bus,
    output logic [CNT_W-1:0]           nnz_total,
    output logic [CNT_W-1:0]           beat_total,
    output logic                       busy
);
    logic [LANES-1:0]   nz;
    logic [BCNT_W-1:0]  pop;
    logic [VEC_W-1:0]   compact;
    logic [2*VEC_W-1:0] res;
    logic [2*VEC_W-1:0] merged;
    logic [BCNT_W-1:0]  fill;
    logic [BCNT_W:0]    nf;
    logic               accept;
    logic               data_hs;
    logic               tensor_done;
    logic [CNT_W-1:0]   nnz_base;
    logic [CNT_W:0]     nnz_sum;
    state_t             state;
    state_t             state_nxt;

    sparse_lane_compact u_compact (
        .vec              (bus.vec_in),
        .double_byte_mode (double_byte_mode),
        .nz               (nz),
        .pop              (pop),
        .compact          (compact)
    );

    assign bus.vec_in_rdy = (state == RUN) & ~bus.mask_vld & ~bus.data_vld;
    assign accept         = bus.vec_in_vld & bus.vec_in_rdy;
    assign data_hs        = bus.data_vld & bus.data_rdy;

    // residue bytes above fill are kept zero, so OR-ing in the shifted new bytes appends them
    assign merged   = res | ({{VEC_W{1'b0}}, compact} << {fill, 3'b000});
    assign nf       = {1'b0, fill} + {1'b0, pop};
    assign nnz_base = tensor_done ? '0 : nnz_total;
    assign nnz_sum  = {1'b0, nnz_base} + (CNT_W+1)'(pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= RUN;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:   if (accept && bus.vec_in_last && nf > (BCNT_W+1)'(LANES)) state_nxt = FLUSH;
            FLUSH: if (data_hs && bus.data_last) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            res            <= '0;
            fill           <= '0;
            bus.mask_out   <= '0;
            bus.mask_vld   <= 1'b0;
            bus.data_out   <= '0;
            bus.data_bytes <= '0;
            bus.data_last  <= 1'b0;
            bus.data_vld   <= 1'b0;
            nnz_total      <= '0;
            beat_total     <= '0;
            busy           <= 1'b0;
            tensor_done    <= 1'b1;
        end else begin
            if (bus.mask_vld && bus.mask_rdy) bus.mask_vld <= 1'b0;

            if (data_hs) begin
                bus.data_vld <= 1'b0;
                if (beat_total != '1) beat_total <= beat_total + 1'b1;
                if (bus.data_last) begin
                    busy        <= 1'b0;
                    tensor_done <= 1'b1;
                end else if (state == FLUSH) begin
                    bus.data_out   <= res[VEC_W-1:0];
                    bus.data_bytes <= fill;
                    bus.data_last  <= 1'b1;
                    bus.data_vld   <= 1'b1;
                    res            <= '0;
                    fill           <= '0;
                end
            end

            if (accept) begin
                bus.mask_out <= nz;
                bus.mask_vld <= 1'b1;
                busy         <= 1'b1;
                tensor_done  <= 1'b0;
                nnz_total    <= nnz_sum[CNT_W] ? '1 : nnz_sum[CNT_W-1:0];
                if (tensor_done) beat_total <= '0;
                if (nf >= (BCNT_W+1)'(LANES)) begin
                    bus.data_out   <= merged[VEC_W-1:0];
                    bus.data_bytes <= BCNT_W'(LANES);
                    bus.data_last  <= bus.vec_in_last && nf == (BCNT_W+1)'(LANES);
                    bus.data_vld   <= 1'b1;
                    res            <= {{VEC_W{1'b0}}, merged[2*VEC_W-1:VEC_W]};
                    fill           <= BCNT_W'(nf - (BCNT_W+1)'(LANES));
                end else if (bus.vec_in_last) begin
                    bus.data_out   <= merged[VEC_W-1:0];
                    bus.data_bytes <= nf[BCNT_W-1:0];
                    bus.data_last  <= 1'b1;
                    bus.data_vld   <= 1'b1;
                    res            <= '0;
                    fill           <= '0;
                end else begin
                    res  <= merged;
                    fill <= nf[BCNT_W-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_sparse_vector_compressor.sv
// tb/tb_sparse_vector_compressor.sv - randomized and directed bench against a byte-queue reference model
module tb_sparse_vector_compressor;
    import sparse_vector_compressor_pkg::*;

    typedef struct {
        logic [127:0] data;
        logic [4:0]   bytes;
        bit           last;
    } beat_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        dbm = 1'b0;
    logic [15:0] nnz_total;
    logic [15:0] beat_total;
    logic        busy;

    sparse_vector_compressor_if bus();

    sparse_vector_compressor dut (
        .clk              (clk),
        .rstn             (rstn),
        .double_byte_mode (dbm),
        .bus              (bus),
        .nnz_total        (nnz_total),
        .beat_total       (beat_total),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  byte_q[$];
    logic [15:0] mask_q[$];
    beat_t       beat_q[$];
    int          m_nnz = 0;
    int          m_beats = 0;
    bit          m_done = 1'b1;
    bit          ctr_chk = 1'b0;
    bit          rand_rdy = 1'b0;
    bit          hold_data = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_accept(input logic [127:0] v, input bit last, input bit dmode);
        logic [15:0] nz;
        int          pop = 0;
        bit          last_done = 1'b0;
        beat_t       b;
        for (int i = 0; i < 16; i++)
            nz[i] = dmode ? (v[(i/2)*16 +: 16] != 16'h0) : (v[i*8 +: 8] != 8'h0);
        mask_q.push_back(nz);
        for (int i = 0; i < 16; i++)
            if (nz[i]) begin
                byte_q.push_back(v[i*8 +: 8]);
                pop++;
            end
        if (m_done) begin
            m_nnz   = 0;
            m_beats = 0;
            m_done  = 1'b0;
        end
        m_nnz = (m_nnz + pop > 65535) ? 65535 : m_nnz + pop;
        while (byte_q.size() >= 16) begin
            b.data = '0;
            for (int j = 0; j < 16; j++) b.data[j*8 +: 8] = byte_q.pop_front();
            b.bytes   = 5'd16;
            b.last    = last && (byte_q.size() == 0);
            last_done = last_done | b.last;
            beat_q.push_back(b);
        end
        if (last && !last_done) begin
            b.data  = '0;
            b.bytes = 5'(byte_q.size());
            for (int j = 0; j < int'(b.bytes); j++) b.data[j*8 +: 8] = byte_q.pop_front();
            b.last  = 1'b1;
            beat_q.push_back(b);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            if (ctr_chk) begin
                ctr_chk = 1'b0;
                check("busy_after_last", busy, 0);
                check("nnz_total", nnz_total, m_nnz);
                check("beat_total", beat_total, m_beats);
            end
            if (bus.mask_vld && bus.mask_rdy) begin
                if (mask_q.size() == 0) check("mask_unexpected", 1, 0);
                else check("mask_out", bus.mask_out, mask_q.pop_front());
            end
            if (bus.data_vld && bus.data_rdy) begin
                if (beat_q.size() == 0) check("beat_unexpected", 1, 0);
                else begin
                    beat_t e;
                    e = beat_q.pop_front();
                    check("data_out", bus.data_out, e.data);
                    check("data_bytes", bus.data_bytes, e.bytes);
                    check("data_last", bus.data_last, e.last);
                    m_beats = (m_beats < 65535) ? m_beats + 1 : 65535;
                    if (e.last) begin
                        m_done  = 1'b1;
                        ctr_chk = 1'b1;
                    end
                end
            end
            if (bus.vec_in_vld && bus.vec_in_rdy) model_accept(bus.vec_in, bus.vec_in_last, dbm);
        end
    end

    initial begin
        bus.mask_rdy = 1'b1;
        bus.data_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.mask_rdy = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
            bus.data_rdy = hold_data ? 1'b0 : (rand_rdy ? ($urandom_range(0, 2) != 0) : 1'b1);
        end
    end

    task automatic send(input logic [127:0] v, input bit last);
        bus.vec_in      = v;
        bus.vec_in_last = last;
        bus.vec_in_vld  = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (bus.vec_in_rdy) break;
            if (t >= 500) begin
                check("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.vec_in_vld  = 1'b0;
        bus.vec_in_last = 1'b0;
    endtask

    task automatic wait_idle();
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (!busy && !bus.mask_vld && !bus.data_vld && !ctr_chk) break;
            if (t >= 1000) begin
                check("idle_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [127:0] v;
        bus.vec_in      = '0;
        bus.vec_in_vld  = 1'b0;
        bus.vec_in_last = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_mask_vld", bus.mask_vld, 0);
        check("rst_data_vld", bus.data_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_nnz", nnz_total, 0);
        check("rst_beats", beat_total, 0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rdy", bus.vec_in_rdy, 1);

        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(i);
        send(v, 1'b1);
        wait_idle();
        check("t1_nnz", nnz_total, 15);
        check("t1_beats", beat_total, 1);

        send({16{8'hAA}}, 1'b0);
        send({16{8'hAA}}, 1'b1);
        wait_idle();
        check("t2_beats", beat_total, 2);
        check("t2_nnz", nnz_total, 32);

        v = '0;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'h11 + 8'(i);
        send(v, 1'b0);
        v = '0;
        for (int i = 0; i < 12; i++) v[i*8 +: 8] = 8'h51 + 8'(i);
        send(v, 1'b1);
        wait_idle();
        check("t3_beats", beat_total, 2);
        check("t3_nnz", nnz_total, 22);

        dbm = 1'b1;
        send(128'h0100, 1'b1);
        wait_idle();
        check("t4_nnz", nnz_total, 2);

        dbm = 1'b0;
        send('0, 1'b1);
        wait_idle();
        check("t5_nnz", nnz_total, 0);
        check("t5_beats", beat_total, 1);

        hold_data = 1'b1;
        @(posedge clk);
        #1;
        v = 128'h5A5B5C5D_5E5F6061_62636465_66676869;
        send(v, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("stall_data_vld", bus.data_vld, 1);
            check("stall_rdy", bus.vec_in_rdy, 0);
            check("stall_data_out", bus.data_out, v);
        end
        hold_data = 1'b0;
        wait_idle();

        v = '0;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = 8'hC0 + 8'(i);
        send(v, 1'b0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b0;
        #1;
        check("midrst_mask_vld", bus.mask_vld, 0);
        check("midrst_data_vld", bus.data_vld, 0);
        check("midrst_busy", busy, 0);
        check("midrst_nnz", nnz_total, 0);
        check("midrst_beats", beat_total, 0);
        byte_q.delete();
        mask_q.delete();
        beat_q.delete();
        m_nnz   = 0;
        m_beats = 0;
        m_done  = 1'b1;
        ctr_chk = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        send('0, 1'b1);
        wait_idle();
        check("postrst_beats", beat_total, 1);

        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            int nvec;
            int dens;
            dbm  = 1'($urandom);
            nvec = $urandom_range(1, 6);
            for (int n = 0; n < nvec; n++) begin
                dens = $urandom_range(0, 4);
                for (int i = 0; i < 16; i++)
                    v[i*8 +: 8] = ($urandom_range(0, 3) < dens) ? 8'($urandom_range(1, 255)) : 8'h00;
                send(v, n == nvec - 1);
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            wait_idle();
        end
        rand_rdy = 1'b0;
        repeat (4) @(posedge clk);
        check("mask_q_drained", 32'(mask_q.size()), 0);
        check("beat_q_drained", 32'(beat_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
